input_conditioner: RTL and testbench

Parametrised multi-channel front-end conditioner for the SDR receive path. Each accepted beat carries CH signed IN_W-bit samples. Each sample is range-checked, optionally clamped, offset to unsigned, rounded and scaled, then saturated to OUT_W bits. The result passes through a 2-stage valid/ready pipeline to the downstream demapper, and a counter tracks beats that contained an out-of-range sample.

---
 rtl/input_conditioner.sv | 153 +++++++++++++++
 tb/tb_input_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel SDR receive front end.
// Per channel: range check, zero/clamp, offset + round, arithmetic shift,
// saturate to OUT_W bits, then a 2-stage valid/ready pipeline.
// Optional clip counter compiled in with INPUT_COND_CLIP_CNT_EN.
module input_conditioner #(
  parameter int CH     = 2,
  parameter int IN_W   = 4,
  parameter int OUT_W  = 6,
  parameter int OFFSET = 8,
  parameter int SHIFT  = 1,
  parameter int LIMIT  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_clip,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      clip_cnt
);

  // Compare width leaves headroom for +/-LIMIT; sum width cannot overflow.
  localparam int CMP_W = IN_W + 2;
  localparam int SUM_W = IN_W + OUT_W + SHIFT + 2;

  localparam logic signed [CMP_W-1:0] LO    = CMP_W'(-LIMIT);
  localparam logic signed [CMP_W-1:0] HI    = CMP_W'(LIMIT);
  localparam logic signed [CMP_W-1:0] HI_M1 = CMP_W'(LIMIT - 1);
  localparam logic signed [SUM_W-1:0] OFF   = SUM_W'(OFFSET);
  // Half an LSB of the shifted result; zero when there is no shift.
  localparam logic signed [SUM_W-1:0] RND   = SUM_W'((1 << SHIFT) >> 1);
  localparam logic signed [SUM_W-1:0] MAXV  = SUM_W'((1 << OUT_W) - 1);

  logic          w_advance;
  logic [CH-1:0] w_oor;
  logic          r_v1;
  logic          r_v2;

  // Both stages move together whenever the output slot is free or draining.
  assign w_advance = !r_v2 || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v2;

  // Stage valids: a bubble enters as valid=0 and is not collapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [IN_W-1:0]  w_x;
      logic signed [CMP_W-1:0] w_x_ext;
      logic signed [CMP_W-1:0] w_xc;
      logic signed [SUM_W-1:0] w_sum;
      logic signed [SUM_W-1:0] w_res;
      logic [OUT_W-1:0]        w_sat;
      logic                    w_lo_oor;
      logic                    w_hi_oor;
      logic signed [SUM_W-1:0] r_sum1;
      logic                    r_clip1;
      logic                    r_zero1;
      logic [OUT_W-1:0]        r_out;
      logic                    r_clip2;

      assign w_x      = in_data[gi*IN_W +: IN_W];
      assign w_x_ext  = {{2{w_x[IN_W-1]}}, w_x};
      assign w_lo_oor = (w_x_ext < LO);
      assign w_hi_oor = (w_x_ext >= HI);
      assign w_oor[gi] = w_lo_oor | w_hi_oor;
      // Clamped value is only meaningful in mode 1; mode 0 uses the zero flag.
      assign w_xc  = w_lo_oor ? LO : (w_hi_oor ? HI_M1 : w_x_ext);
      assign w_sum = {{(SUM_W-CMP_W){w_xc[CMP_W-1]}}, w_xc} + OFF + RND;

      // Stage 1: range flag, zero decision (mode captured here) and sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum1  <= '0;
          r_clip1 <= 1'b0;
          r_zero1 <= 1'b0;
        end else if (w_advance) begin
          r_sum1  <= w_sum;
          r_clip1 <= w_oor[gi];
          r_zero1 <= w_oor[gi] && !mode;
        end
      end

      assign w_res = r_sum1 >>> SHIFT;

      // Shift result saturated into the unsigned output range.
      always_comb begin
        w_sat = w_res[OUT_W-1:0];
        if (r_zero1 || w_res[SUM_W-1]) begin
          w_sat = '0;
        end else if (w_res > MAXV) begin
          w_sat = '1;
        end
      end

      // Stage 2: output register, held while the consumer stalls.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out   <= '0;
          r_clip2 <= 1'b0;
        end else if (w_advance) begin
          r_out   <= w_sat;
          r_clip2 <= r_clip1;
        end
      end

      assign out_data[gi*OUT_W +: OUT_W] = r_out;
      assign out_clip[gi]                = r_clip2;
    end
  endgenerate

`ifdef INPUT_COND_CLIP_CNT_EN
  logic [CNT_W-1:0] r_clip_cnt;
  logic             w_accept;

  assign w_accept = in_valid && w_advance;

  // Saturating count of accepted beats with any clipped channel; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip_cnt <= '0;
    end else if (cnt_clr) begin
      r_clip_cnt <= '0;
    end else if (w_accept && (|w_oor) && !(&r_clip_cnt)) begin
      r_clip_cnt <= r_clip_cnt + 1'b1;
    end
  end

  assign clip_cnt = r_clip_cnt;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign clip_cnt         = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed checks followed by randomized
// traffic scored against an arithmetic reference model.
// Counter expectations follow INPUT_COND_CLIP_CNT_EN (zero when undefined).
module tb_input_conditioner;

  localparam int CH     = 2;
  localparam int IN_W   = 4;
  localparam int OUT_W  = 6;
  localparam int OFFSET = 8;
  localparam int SHIFT  = 1;
  localparam int LIMIT  = 6;
  localparam int CNT_W  = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [CH*IN_W-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [CH*OUT_W-1:0] out_data;
  logic [CH-1:0]       out_clip;
  logic                cnt_clr;
  logic [CNT_W-1:0]    clip_cnt;

  logic                c2_unused_ready;
  logic                c2_unused_valid;
  logic [CH*OUT_W-1:0] c2_unused_data;
  logic [CH-1:0]       c2_unused_clip;
  logic [1:0]          c2_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int exp_cnt  = 0;
  int exp_cnt2 = 0;

  logic [CH*OUT_W-1:0] q_data[$];
  logic [CH-1:0]       q_clip[$];

  always #5 clk = ~clk;

  input_conditioner #(
    .CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .OFFSET(OFFSET),
    .SHIFT(SHIFT), .LIMIT(LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_clip(out_clip),
    .cnt_clr(cnt_clr), .clip_cnt(clip_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  input_conditioner #(
    .CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .OFFSET(OFFSET),
    .SHIFT(SHIFT), .LIMIT(LIMIT), .CNT_W(2)
  ) dut_c2 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
    .in_ready(c2_unused_ready), .in_data(in_data), .out_valid(c2_unused_valid),
    .out_ready(out_ready), .out_data(c2_unused_data), .out_clip(c2_unused_clip),
    .cnt_clr(cnt_clr), .clip_cnt(c2_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef INPUT_COND_CLIP_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  // Reference: each channel computed with plain integer arithmetic.
  function automatic void model_beat(input logic [CH*IN_W-1:0] d, input logic m,
                                     output logic [CH*OUT_W-1:0] od,
                                     output logic [CH-1:0] oc);
    logic signed [IN_W-1:0] xs;
    int x;
    int r;
    od = '0;
    oc = '0;
    for (int c = 0; c < CH; c++) begin
      xs = d[c*IN_W +: IN_W];
      x  = xs;
      if (x < -LIMIT || x >= LIMIT) begin
        oc[c] = 1'b1;
        if (x < 0) x = -LIMIT;
        else       x = LIMIT - 1;
      end
      if (oc[c] && !m) begin
        r = 0;
      end else begin
        r = floor_div(x + OFFSET + (2 ** SHIFT) / 2, 2 ** SHIFT);
        if (r < 0) r = 0;
        if (r > 2 ** OUT_W - 1) r = 2 ** OUT_W - 1;
      end
      od[c*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
  endfunction

  // One cycle of scoreboarded traffic: drive, check outputs, update model.
  task automatic step(input logic iv, input logic [CH*IN_W-1:0] d, input logic m,
                      input logic ordy, input logic clr, output logic acc);
    logic [CH*OUT_W-1:0] ed;
    logic [CH-1:0]       ec;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    mode      = m;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    check_eq("in_ready", in_ready, !out_valid || out_ready);
    check_eq("clip_cnt", clip_cnt, cnt_exp(exp_cnt));
    check_eq("clip_cnt_w2", c2_cnt, cnt_exp(exp_cnt2));
    if (out_valid) begin
      if (q_data.size() == 0) begin
        check_eq("spurious_beat", out_valid, 0);
      end else begin
        check_eq("out_data", out_data, q_data[0]);
        check_eq("out_clip", out_clip, q_clip[0]);
        if (out_ready) begin
          void'(q_data.pop_front());
          void'(q_clip.pop_front());
          n_out++;
        end
      end
    end
    acc = iv && in_ready;
    model_beat(d, m, ed, ec);
    if (clr) begin
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else if (acc && (|ec)) begin
      if (exp_cnt < 2 ** CNT_W - 1) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    if (acc) begin
      q_data.push_back(ed);
      q_clip.push_back(ec);
    end
  endtask

  // Single isolated beat with explicit two-edge latency check.
  task automatic send_check(input string tag, input logic [CH*IN_W-1:0] d, input logic m,
                            input logic clr, input logic [CH*OUT_W-1:0] ed,
                            input logic [CH-1:0] ec);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    out_ready = 1'b1;
    cnt_clr   = clr;
    #1;
    check_eq({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    check_eq({tag, "_valid_e1"}, out_valid, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid_e2"}, out_valid, 1);
    check_eq({tag, "_data"}, out_data, ed);
    check_eq({tag, "_clip"}, out_clip, ec);
    @(posedge clk);
    #1;
    check_eq({tag, "_valid_e3"}, out_valid, 0);
  endtask

  initial begin
    logic                acc;
    logic [CH*IN_W-1:0]  d;
    logic                m;
    int                  sent;
    int                  out0;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_clip", out_clip, 0);
    check_eq("rst_clip_cnt", clip_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // ch1=5, ch0=0 -> 7, 4
    send_check("single", 8'h50, 1'b0, 1'b0, {6'd7, 6'd4}, 2'b00);
    check_eq("single_cnt", clip_cnt, 0);
    // ch1=7 (out of range, zeroed), ch0=-6 (in range) -> 0, 1
    send_check("bound_m0", 8'h7A, 1'b0, 1'b0, {6'd0, 6'd1}, 2'b10);
    check_eq("bound_cnt", clip_cnt, cnt_exp(1));
    // ch1=7 clamps to 5, ch0=-8 clamps to -6 -> 7, 1
    send_check("clamp_m1", 8'h78, 1'b1, 1'b0, {6'd7, 6'd1}, 2'b11);
    check_eq("clamp_cnt", clip_cnt, cnt_exp(2));
    for (int i = 0; i < 5; i++) begin
      send_check("sat", 8'h78, 1'b1, 1'b0, {6'd7, 6'd1}, 2'b11);
    end
    check_eq("sat_cnt16", clip_cnt, cnt_exp(7));
    check_eq("sat_cnt2", c2_cnt, cnt_exp(3));
    send_check("clr", 8'h78, 1'b1, 1'b1, {6'd7, 6'd1}, 2'b11);
    check_eq("clr_cnt16", clip_cnt, 0);
    check_eq("clr_cnt2", c2_cnt, 0);

    // Back-pressure: 5 beats, out_ready low for 3 cycles mid-stream.
    exp_cnt = 0; exp_cnt2 = 0; sent = 0; out0 = n_out;
    d = 8'($urandom); m = 1'($urandom);
    for (int cyc = 0; cyc < 40 && (sent < 5 || q_data.size() > 0); cyc++) begin
      step(sent < 5, d, m, !(cyc >= 2 && cyc <= 4), 1'b0, acc);
      if (acc) begin
        sent++;
        d = 8'($urandom);
        m = 1'($urandom);
      end
    end
    check_eq("bp_sent", sent, 5);
    check_eq("bp_received", n_out - out0, 5);

    // Async reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1; mode = 1'b0;
    @(negedge clk);
    in_data = 8'h7F;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_out_clip", out_clip, 0);
    check_eq("arst_clip_cnt", clip_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_in_ready", in_ready, 1);
    send_check("post_rst", 8'h00, 1'b0, 1'b0, {6'd4, 6'd4}, 2'b00);

    // Randomized traffic against the model.
    q_data.delete(); q_clip.delete();
    exp_cnt = 0; exp_cnt2 = 0;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
    end
    for (int i = 0; i < 20 && q_data.size() > 0; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    end
    check_eq("drain_empty", q_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
